// File: rtl/bios_loader.sv
// Boot-time copy engine: streams the BIOS image from SPI flash into its SD-RAM shadow region.
// Define BIOS_LOADER_CHECKSUM_EN to add a 16-bit running CHECKSUM of every byte written.
module bios_loader #(
    parameter logic [23:0] SRC_ADDR   = 24'h10_0000,
    parameter logic [23:0] DST_ADDR   = 24'h70_0000,
    parameter logic [23:0] LENGTH     = 24'h02_4000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RESET_n,
    input  logic        START,
    output logic        FLASH_CMD_REQ,
    output logic [23:0] FLASH_CMD_ADDR,
    output logic [23:0] FLASH_CMD_LEN,
    input  logic        FLASH_CMD_ACK,
    input  logic [7:0]  FLASH_DATA,
    input  logic        FLASH_VALID,
    output logic        FLASH_READY,
    output logic        RAM_REQ,
    output logic [23:0] RAM_ADDR,
    output logic [7:0]  RAM_WDATA,
    input  logic        RAM_ACK,
    output logic        BUSY,
    output logic        DONE
`ifdef BIOS_LOADER_CHECKSUM_EN
    ,
    output logic [15:0] CHECKSUM
`endif
);

    localparam int              PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int              CW        = PW + 1;
    localparam logic [CW-1:0]   FULL_CNT  = CW'(FIFO_DEPTH);
    localparam logic [23:0]     LAST_IDX  = LENGTH - 24'd1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD     = 2'd1,
        COPY    = 2'd2,
        DONE_ST = 2'd3
    } state_t;

    state_t        state;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] fifo_cnt;
    logic [CW-1:0] fifo_cnt_nxt;
    logic          fifo_full;
    logic [23:0]   rx_cnt;
    logic [23:0]   wr_cnt;
    logic          cmd_req;
    logic          busy_q;
    logic          done_q;
    logic          flash_ready;
    logic          ram_req;
    logic          push;
    logic          pop;
    logic          start_ok;

    // Full flag is registered, so a pop in the same cycle does not reopen READY until the next one.
    assign flash_ready = (state == COPY) && !fifo_full && (rx_cnt < LENGTH);
    assign push        = FLASH_VALID && flash_ready;
    assign ram_req     = (state == COPY) && (fifo_cnt != '0);
    assign pop         = ram_req && RAM_ACK;
    assign start_ok    = START && ((state == IDLE) || (state == DONE_ST));

    always_comb begin
        fifo_cnt_nxt = fifo_cnt;
        if (push && !pop) begin
            fifo_cnt_nxt = fifo_cnt + 1'b1;
        end else if (!push && pop) begin
            fifo_cnt_nxt = fifo_cnt - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= FLASH_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            fifo_full <= 1'b0;
            rx_cnt    <= '0;
            wr_cnt    <= '0;
            cmd_req   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            fifo_cnt  <= fifo_cnt_nxt;
            fifo_full <= (fifo_cnt_nxt == FULL_CNT);
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                rx_cnt <= rx_cnt + 24'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                wr_cnt <= wr_cnt + 24'd1;
            end
            case (state)
                IDLE, DONE_ST: begin
                    if (START) begin
                        rx_cnt <= '0;
                        wr_cnt <= '0;
                        if (LENGTH == 24'd0) begin
                            state  <= DONE_ST;
                            done_q <= 1'b1;
                        end else begin
                            state   <= CMD;
                            cmd_req <= 1'b1;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end
                end
                CMD: begin
                    if (FLASH_CMD_ACK) begin
                        state   <= COPY;
                        cmd_req <= 1'b0;
                    end
                end
                COPY: begin
                    if (pop && (wr_cnt == LAST_IDX)) begin
                        state  <= DONE_ST;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BIOS_LOADER_CHECKSUM_EN
    logic [15:0] sum_q;

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            sum_q <= '0;
        end else if (start_ok) begin
            sum_q <= '0;
        end else if (pop) begin
            sum_q <= sum_q + {8'h00, fifo_mem[rd_ptr]};
        end
    end

    assign CHECKSUM = sum_q;
`endif

    assign FLASH_CMD_REQ  = cmd_req;
    assign FLASH_CMD_ADDR = cmd_req ? SRC_ADDR : '0;
    assign FLASH_CMD_LEN  = cmd_req ? LENGTH : '0;
    assign FLASH_READY    = flash_ready;
    assign RAM_REQ        = ram_req;
    assign RAM_ADDR       = ram_req ? (DST_ADDR + wr_cnt) : '0;
    assign RAM_WDATA      = ram_req ? fifo_mem[rd_ptr] : '0;
    assign BUSY           = busy_q;
    assign DONE           = done_q;

endmodule

// File: tb/tb_bios_loader.sv
// Scoreboard bench for bios_loader: a 16-byte instance for the copy scenarios and a zero-length instance.
module tb_bios_loader;

    localparam logic [23:0] SRC = 24'h10_0000;
    localparam logic [23:0] DST = 24'h70_0000;
    localparam logic [23:0] LEN = 24'd16;

    logic        clk = 1'b0;
    logic        RESET_n;
    logic        START;
    logic        FLASH_CMD_REQ;
    logic [23:0] FLASH_CMD_ADDR;
    logic [23:0] FLASH_CMD_LEN;
    logic        FLASH_CMD_ACK;
    logic [7:0]  FLASH_DATA;
    logic        FLASH_VALID;
    logic        FLASH_READY;
    logic        RAM_REQ;
    logic [23:0] RAM_ADDR;
    logic [7:0]  RAM_WDATA;
    logic        RAM_ACK;
    logic        BUSY;
    logic        DONE;

    logic        z_start;
    logic        z_cmd_req;
    logic [23:0] z_cmd_addr;
    logic [23:0] z_cmd_len;
    logic        z_ready;
    logic        z_ram_req;
    logic [23:0] z_ram_addr;
    logic [7:0]  z_ram_wdata;
    logic        z_busy;
    logic        z_done;
    logic        z_bad = 1'b0;

`ifdef BIOS_LOADER_CHECKSUM_EN
    logic [15:0] CHECKSUM;
    logic [15:0] z_checksum;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int flash_pct = 100;
    int ack_pct = 100;
    bit ack_hold = 1'b0;
    int idx = 0;
    int accepted = 0;
    int writes = 0;
    int cmd_count = 0;
    int first_acc_cyc = -1;
    int first_req_cyc = -1;
    int last_ack_cyc = -1;
    logic [31:0] exp_q [$];

    bios_loader #(.SRC_ADDR(SRC), .DST_ADDR(DST), .LENGTH(LEN), .FIFO_DEPTH(4)) dut (
        .CLK(clk), .RESET_n(RESET_n), .START(START),
        .FLASH_CMD_REQ(FLASH_CMD_REQ), .FLASH_CMD_ADDR(FLASH_CMD_ADDR), .FLASH_CMD_LEN(FLASH_CMD_LEN),
        .FLASH_CMD_ACK(FLASH_CMD_ACK), .FLASH_DATA(FLASH_DATA), .FLASH_VALID(FLASH_VALID),
        .FLASH_READY(FLASH_READY), .RAM_REQ(RAM_REQ), .RAM_ADDR(RAM_ADDR), .RAM_WDATA(RAM_WDATA),
        .RAM_ACK(RAM_ACK), .BUSY(BUSY), .DONE(DONE)
`ifdef BIOS_LOADER_CHECKSUM_EN
        , .CHECKSUM(CHECKSUM)
`endif
    );

    bios_loader #(.SRC_ADDR(SRC), .DST_ADDR(DST), .LENGTH(24'd0), .FIFO_DEPTH(4)) dut0 (
        .CLK(clk), .RESET_n(RESET_n), .START(z_start),
        .FLASH_CMD_REQ(z_cmd_req), .FLASH_CMD_ADDR(z_cmd_addr), .FLASH_CMD_LEN(z_cmd_len),
        .FLASH_CMD_ACK(1'b1), .FLASH_DATA(8'h55), .FLASH_VALID(1'b1),
        .FLASH_READY(z_ready), .RAM_REQ(z_ram_req), .RAM_ADDR(z_ram_addr), .RAM_WDATA(z_ram_wdata),
        .RAM_ACK(1'b1), .BUSY(z_busy), .DONE(z_done)
`ifdef BIOS_LOADER_CHECKSUM_EN
        , .CHECKSUM(z_checksum)
`endif
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: actual=still running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] srcByte(input int i);
        return 8'((i * 37 + 90) & 255);
    endfunction

    function automatic logic [15:0] expSum();
        logic [15:0] s = '0;
        for (int i = 0; i < 16; i++) s = s + {8'h00, srcByte(i)};
        return s;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus();
        idx = 0;
        accepted = 0;
        writes = 0;
        cmd_count = 0;
        first_acc_cyc = -1;
        first_req_cyc = -1;
        @(negedge clk);
        START = 1'b1;
        @(negedge clk);
        START = 1'b0;
        checkOutput("start_done_clear", DONE, 0);
        checkOutput("start_busy", BUSY, 1);
        checkOutput("start_cmd_req", FLASH_CMD_REQ, 1);
    endtask

    task automatic waitDone(input int budget, output int dcyc);
        dcyc = -1;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (DONE) begin
                dcyc = cyc;
                break;
            end
        end
        if (dcyc < 0) begin
            failures++;
            checks++;
            $display("[TB] FAIL done_timeout: actual=DONE 0 required=DONE 1");
        end
    endtask

    task automatic waitWrites(input int target, input int budget);
        bit ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (writes >= target) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            failures++;
            checks++;
            $display("[TB] FAIL writes_timeout: actual=%0d required=%0d", writes, target);
        end
    endtask

    task automatic resetChecks(input string tag);
        checkOutput({tag, "_cmd_req"}, FLASH_CMD_REQ, 0);
        checkOutput({tag, "_cmd_addr"}, FLASH_CMD_ADDR, 0);
        checkOutput({tag, "_cmd_len"}, FLASH_CMD_LEN, 0);
        checkOutput({tag, "_ready"}, FLASH_READY, 0);
        checkOutput({tag, "_ram_req"}, RAM_REQ, 0);
        checkOutput({tag, "_ram_addr"}, RAM_ADDR, 0);
        checkOutput({tag, "_ram_wdata"}, RAM_WDATA, 0);
        checkOutput({tag, "_busy"}, BUSY, 0);
        checkOutput({tag, "_done"}, DONE, 0);
    endtask

    task automatic checkCopyEnd(input string tag);
        checkOutput({tag, "_accepted"}, accepted, 16);
        checkOutput({tag, "_writes"}, writes, 16);
        checkOutput({tag, "_queue_left"}, exp_q.size(), 0);
        checkOutput({tag, "_cmds"}, cmd_count, 1);
        checkOutput({tag, "_busy"}, BUSY, 0);
        checkOutput({tag, "_ram_req"}, RAM_REQ, 0);
`ifdef BIOS_LOADER_CHECKSUM_EN
        checkOutput({tag, "_checksum"}, CHECKSUM, expSum());
`endif
    endtask

    // Flash model: answers the command, offers the source image and logs every accepted byte.
    initial begin
        FLASH_CMD_ACK = 1'b0;
        FLASH_VALID = 1'b0;
        FLASH_DATA = 8'h00;
        forever begin
            @(negedge clk);
            FLASH_CMD_ACK = FLASH_CMD_REQ;
            FLASH_VALID = ($urandom_range(99) < flash_pct);
            FLASH_DATA = srcByte(idx);
            #1;
            if (FLASH_VALID && FLASH_READY) begin
                exp_q.push_back({DST + 24'(idx), srcByte(idx)});
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
                idx++;
                accepted++;
            end
        end
    end

    initial begin
        RAM_ACK = 1'b0;
        forever begin
            @(negedge clk);
            RAM_ACK = !ack_hold && ($urandom_range(99) < ack_pct);
        end
    end

    // Monitor: pops the scoreboard on each accepted RAM write and checks held requests stay put.
    initial begin
        logic [31:0] e;
        bit          pend_valid = 1'b0;
        logic [23:0] pend_addr = '0;
        logic [7:0]  pend_data = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!RESET_n) begin
                pend_valid = 1'b0;
            end else begin
                if (pend_valid) begin
                    checkOutput("ram_req_held", RAM_REQ, 1);
                    checkOutput("ram_addr_held", RAM_ADDR, pend_addr);
                    checkOutput("ram_wdata_held", RAM_WDATA, pend_data);
                end
                if (FLASH_CMD_REQ && FLASH_CMD_ACK) begin
                    cmd_count++;
                    checkOutput("cmd_addr", FLASH_CMD_ADDR, SRC);
                    checkOutput("cmd_len", FLASH_CMD_LEN, LEN);
                end
                if (RAM_REQ && first_req_cyc < 0) first_req_cyc = cyc;
                if (RAM_REQ && RAM_ACK) begin
                    pend_valid = 1'b0;
                    writes++;
                    last_ack_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected_write: actual=addr %0h required=no write", RAM_ADDR);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("ram_addr", RAM_ADDR, e[31:8]);
                        checkOutput("ram_wdata", RAM_WDATA, e[7:0]);
                    end
                end else if (RAM_REQ) begin
                    pend_valid = 1'b1;
                    pend_addr = RAM_ADDR;
                    pend_data = RAM_WDATA;
                end else begin
                    pend_valid = 1'b0;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        #2;
        if (z_cmd_req || z_ram_req || z_ready) z_bad = 1'b1;
    end

    initial begin
        int d;
        RESET_n = 1'b0;
        START = 1'b0;
        z_start = 1'b0;
        repeat (3) @(negedge clk);
        resetChecks("por");
        RESET_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full-rate copy
        applyStimulus();
        waitDone(200, d);
        checkOutput("t1_done_latency", d - last_ack_cyc, 1);
        checkOutput("t1_first_req_latency", first_req_cyc - first_acc_cyc, 1);
        checkCopyEnd("t1");

        // Restart from DONE, stall RAM for 10 cycles and pulse START while busy
        applyStimulus();
        waitWrites(3, 200);
        ack_hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 4) START = 1'b1;
            if (i == 5) START = 1'b0;
        end
        checkOutput("t2_ready_full", FLASH_READY, 0);
        checkOutput("t2_req_held", RAM_REQ, 1);
        checkOutput("t2_occupancy", accepted - writes, 4);
        ack_hold = 1'b0;
        waitDone(200, d);
        checkCopyEnd("t2");

        // Random flash and RAM handshakes
        flash_pct = 30;
        ack_pct = 50;
        applyStimulus();
        waitDone(3000, d);
        checkCopyEnd("t3");

        // Reset mid-copy, then a fresh copy
        flash_pct = 100;
        ack_pct = 100;
        applyStimulus();
        waitWrites(7, 200);
        #3 RESET_n = 1'b0;
        #1 resetChecks("rst_mid");
        repeat (2) @(negedge clk);
        exp_q.delete();
        RESET_n = 1'b1;
        @(negedge clk);
        applyStimulus();
        waitDone(200, d);
        checkCopyEnd("t4");

        // Zero-length copy
        @(negedge clk);
        z_start = 1'b1;
        @(negedge clk);
        z_start = 1'b0;
        checkOutput("z_done_1cyc", z_done, 1);
        @(negedge clk);
        checkOutput("z_done_held", z_done, 1);
        checkOutput("z_busy", z_busy, 0);
        repeat (3) @(negedge clk);
        checkOutput("z_no_traffic", z_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
